// File: rtl/rotate_seq_ctrl.sv
// Sequenced rotate/shift unit: resolves the shift amount one binary stage per clock,
// bit k of the amount moving the operand by 2^k. Valid/ready handshake on both sides.
module rotate_seq_ctrl #(
  parameter int WIDTH      = 32,
  parameter int STAGES     = 5,
  parameter bit EARLY_DONE = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [1:0]           op,
  input  logic                 abort,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 busy
);

  localparam int KW = (STAGES > 1) ? $clog2(STAGES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} stateE;
  typedef enum logic [1:0] {OP_ROR = 2'b00, OP_ROL = 2'b01, OP_SRL = 2'b10, OP_SLL = 2'b11} opE;

  stateE            state, nextState;
  opE               opReg;
  logic [WIDTH-1:0] dataReg, resultReg, stageVal;
  logic [STAGES-1:0] amtReg;
  logic [KW-1:0]    stageCnt;
  int unsigned      shiftBy;
  logic             accept, lastStage;

  // Only the low amount bits matter; the amount is taken modulo WIDTH.
  logic unusedB;
  assign unusedB = ^b[WIDTH-1:STAGES];

  assign shiftBy = 32'd1 << stageCnt;

  always_comb begin
    stageVal = dataReg;
    if (amtReg[stageCnt]) begin
      unique case (opReg)
        OP_ROR: stageVal = (dataReg >> shiftBy) | (dataReg << (WIDTH - shiftBy));
        OP_ROL: stageVal = (dataReg << shiftBy) | (dataReg >> (WIDTH - shiftBy));
        OP_SRL: stageVal = dataReg >> shiftBy;
        OP_SLL: stageVal = dataReg << shiftBy;
        default: stageVal = dataReg;
      endcase
    end
  end

  // Stop once the final stage is reached, or early when no higher amount bits remain.
  assign lastStage = (stageCnt == KW'(STAGES - 1)) ||
                     (EARLY_DONE && ((amtReg >> (int'(stageCnt) + 1)) == '0));

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    nextState = state;
    accept    = 1'b0;
    unique case (state)
      IDLE: begin
        if (in_valid && !abort) begin
          accept    = 1'b1;
          nextState = (EARLY_DONE && (b[STAGES-1:0] == '0)) ? DONE : RUN;
        end
      end
      RUN: begin
        if (abort)          nextState = IDLE;
        else if (lastStage) nextState = DONE;
      end
      DONE: begin
        if (abort || out_ready) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      dataReg   <= '0;
      resultReg <= '0;
      amtReg    <= '0;
      stageCnt  <= '0;
      opReg     <= OP_ROR;
    end else begin
      state <= nextState;
      if (accept) begin
        dataReg  <= a;
        amtReg   <= b[STAGES-1:0];
        opReg    <= opE'(op);
        stageCnt <= '0;
        if (nextState == DONE) resultReg <= a;
      end else if (state == RUN && !abort) begin
        dataReg  <= stageVal;
        stageCnt <= stageCnt + 1'b1;
        if (lastStage) resultReg <= stageVal;
      end
    end
  end

  // resultReg only changes on entry to DONE, so the value holds until the next completion.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign result    = {{WIDTH{1'b0}}, resultReg};

endmodule

// File: tb/tb_rotate_seq_ctrl.sv
// Bench for rotate_seq_ctrl: table-driven vectors on an early-done instance plus
// hand sequences for fixed latency, backpressure, abort and asynchronous reset.
module tb_rotate_seq_ctrl;

  typedef enum logic [1:0] {ROR = 2'b00, ROL = 2'b01, SRL = 2'b10, SLL = 2'b11} opT;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic [31:0] exp;
    int          lat;   // edges after accept until out_valid; -1 = not checked
  } vecT;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] a = '0, b = '0;
  logic [1:0]  op = '0;

  logic        inValid = 1'b0, outReady = 1'b0, abort = 1'b0;
  logic        inReady, outValid, busy;
  logic [63:0] result;

  logic        inValidF = 1'b0, outReadyF = 1'b0, abortF = 1'b0;
  logic        inReadyF, outValidF, busyF;
  logic [63:0] resultF;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  rotate_seq_ctrl #(.WIDTH(32), .STAGES(5), .EARLY_DONE(1'b1)) dutE (
    .clock(clock), .reset(reset), .in_valid(inValid), .in_ready(inReady),
    .a(a), .b(b), .op(op), .abort(abort), .out_valid(outValid),
    .out_ready(outReady), .result(result), .busy(busy)
  );

  rotate_seq_ctrl #(.WIDTH(32), .STAGES(5), .EARLY_DONE(1'b0)) dutF (
    .clock(clock), .reset(reset), .in_valid(inValidF), .in_ready(inReadyF),
    .a(a), .b(b), .op(op), .abort(abortF), .out_valid(outValidF),
    .out_ready(outReadyF), .result(resultF), .busy(busyF)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] rorModel(input logic [31:0] x, input int n);
    int m;
    m = n % 32;
    if (m == 0) return x;
    return (x >> m) | (x << (32 - m));
  endfunction

  // Presents a request for one cycle, then scrambles the operands after the accept edge.
  task automatic issue(input bit fixed, input logic [31:0] va, input logic [31:0] vb,
                       input logic [1:0] vop);
    @(negedge clock);
    a = va; b = vb; op = vop;
    if (fixed) inValidF = 1'b1; else inValid = 1'b1;
    @(negedge clock);
    inValidF = 1'b0; inValid = 1'b0;
    a = ~va; b = vb + 32'd7; op = ~vop;
  endtask

  // Called at the first falling edge after the accept edge; counts edges until out_valid.
  task automatic waitDone(input bit fixed, output int lat);
    lat = 0;
    while (!(fixed ? outValidF : outValid) && lat < 20) begin
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic consume(input bit fixed);
    if (fixed) outReadyF = 1'b1; else outReady = 1'b1;
    @(negedge clock);
    outReadyF = 1'b0; outReady = 1'b0;
  endtask

  vecT vecs[10];

  initial begin
    int lat;
    int seen;
    logic [63:0] held;

    vecs[0] = '{32'h8000_0001, 32'd1,  ROR, 32'hC000_0000, 1};
    vecs[1] = '{32'h1234_5678, 32'd37, ROR, 32'hC091_A2B3, 3};
    vecs[2] = '{32'hFFFF_FFFF, 32'd31, SLL, 32'h8000_0000, 5};
    vecs[3] = '{32'hF000_0000, 32'd4,  SRL, 32'h0F00_0000, 3};
    vecs[4] = '{32'h1234_5678, 32'd8,  ROL, 32'h3456_7812, 4};
    vecs[5] = '{32'hDEAD_BEEF, 32'd64, ROR, 32'hDEAD_BEEF, -1};
    vecs[6] = '{32'h8000_0000, 32'd1,  ROL, 32'h0000_0001, 1};
    vecs[7] = '{32'h0000_0001, 32'd16, SLL, 32'h0001_0000, 5};
    vecs[8] = '{32'h8000_0000, 32'd31, SRL, 32'h0000_0001, 5};
    vecs[9] = '{32'h0000_000F, 32'd6,  ROR, 32'h3C00_0000, 3};

    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("reset in_ready",  inReady,   1);
    check("reset out_valid", outValid,  0);
    check("reset busy",      busy,      0);
    check("reset result",    result,    0);
    check("reset F in_ready", inReadyF, 1);
    check("reset F busy",     busyF,    0);
    check("reset F result",   resultF,  0);

    for (int i = 0; i < 10; i++) begin
      issue(1'b0, vecs[i].a, vecs[i].b, vecs[i].op);
      waitDone(1'b0, lat);
      check($sformatf("vec%0d out_valid", i), outValid, 1);
      check($sformatf("vec%0d result", i), result, {32'h0, vecs[i].exp});
      if (vecs[i].lat >= 0) check($sformatf("vec%0d latency", i), lat, vecs[i].lat);
      if (vecs[i].op == ROL)
        check($sformatf("vec%0d rol identity", i), result[31:0],
              rorModel(vecs[i].a, 32 - int'(vecs[i].b[4:0])));
      consume(1'b0);
    end

    // Fixed latency instance: always 5 edges, including amount 0.
    issue(1'b1, 32'h1234_5678, 32'd8, ROL);
    waitDone(1'b1, lat);
    check("fixed rol latency", lat, 5);
    check("fixed rol result", resultF, {32'h0, 32'h3456_7812});
    check("fixed rol identity", resultF[31:0], rorModel(32'h1234_5678, 24));
    consume(1'b1);
    issue(1'b1, 32'hCAFE_F00D, 32'd0, ROR);
    waitDone(1'b1, lat);
    check("fixed amt0 latency", lat, 5);
    check("fixed amt0 result", resultF, {32'h0, 32'hCAFE_F00D});
    consume(1'b1);

    // Backpressure: result held while out_ready is low, no acceptance from DONE.
    issue(1'b0, 32'h0000_0001, 32'd3, SLL);
    waitDone(1'b0, lat);
    check("bp latency", lat, 2);
    check("bp result", result, {32'h0, 32'h0000_0008});
    held = {32'h0, 32'h0000_0008};
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check($sformatf("bp hold%0d out_valid", k), outValid, 1);
      check($sformatf("bp hold%0d result", k), result, held);
      check($sformatf("bp hold%0d in_ready", k), inReady, 0);
    end
    outReady = 1'b1;
    inValid = 1'b1; a = 32'h0000_0004; b = 32'd2; op = ROR;
    @(negedge clock);
    outReady = 1'b0;
    check("bp idle in_ready", inReady, 1);
    check("bp idle out_valid", outValid, 0);
    @(negedge clock);
    inValid = 1'b0; a = 32'hFFFF_FFFF; b = 32'd9;
    check("bp next accepted", busy, 1);
    check("bp next in_ready", inReady, 0);
    waitDone(1'b0, lat);
    check("bp next latency", lat, 2);
    check("bp next result", result, {32'h0, 32'h0000_0001});
    consume(1'b0);

    // Abort in RUN at stage 2: back to IDLE, no result.
    issue(1'b0, 32'h1234_5678, 32'd31, ROR);
    repeat (2) @(negedge clock);
    check("abort pre busy", busy, 1);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    check("abort out_valid", outValid, 0);
    check("abort in_ready", inReady, 1);
    check("abort busy", busy, 0);
    seen = 0;
    repeat (6) begin
      @(negedge clock);
      if (outValid) seen++;
    end
    check("abort no out_valid", seen, 0);

    // Abort in IDLE suppresses acceptance.
    inValid = 1'b1; abort = 1'b1; a = 32'h5; b = 32'd1; op = SRL;
    @(negedge clock);
    inValid = 1'b0; abort = 1'b0;
    check("idle abort busy", busy, 0);
    check("idle abort in_ready", inReady, 1);

    // Asynchronous reset while in DONE.
    issue(1'b0, 32'hF0F0_F0F0, 32'd1, SRL);
    waitDone(1'b0, lat);
    check("pre-reset out_valid", outValid, 1);
    #2 reset = 1'b1;
    #1;
    check("async reset out_valid", outValid, 0);
    check("async reset in_ready", inReady, 1);
    check("async reset busy", busy, 0);
    check("async reset result", result, 0);
    @(negedge clock);
    reset = 1'b0;
    issue(1'b0, 32'hF000_0000, 32'd4, SRL);
    waitDone(1'b0, lat);
    check("post-reset latency", lat, 3);
    check("post-reset result", result, {32'h0, 32'h0F00_0000});
    consume(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
